memory_ram_sdp: RTL and testbench

Simple dual-port synchronous RAM (one write port, one read port, both usable every cycle), the parametrised successor to the single-port local memory used by the AXI Stream coprocessors. It adds:
- byte-lane write enables
- selectable read latency (1 or 2)
- selectable read-during-write behaviour
- a read_valid strobe
- an optional post-reset zero-clear sequencer, so coprocessor memories start from a known state

---
 rtl/memory_pkg.sv | 17 +
 rtl/memory_ram_sdp_init.sv | 71 +++++++
 rtl/memory_ram_sdp.sv | 126 ++++++++++++
 tb/tb_memory_ram_sdp.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the simple dual-port RAM: clear-sequencer states,
// legal read latencies and the byte-lane count helper.
package memory_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    localparam int READ_LATENCY_ONE = 1;
    localparam int READ_LATENCY_TWO = 2;

    function automatic int lanes(input int width, input int byte_width);
        return width / byte_width;
    endfunction

endpackage

// File: rtl/memory_ram_sdp_init.sv
// Post-reset clear sequencer: sweeps zeros through the write port, then hands
// the write port to the external interface for good.
module memory_ram_sdp_init
    import memory_pkg::*;
#(
    parameter int width          = 32,
    parameter int depth_bits     = 4,
    parameter int byte_width     = 8,
    parameter int clear_on_reset = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write_en_i,
    input  logic [lanes(width, byte_width)-1:0] write_byte_en_i,
    input  logic [depth_bits-1:0]               write_address_i,
    input  logic [width-1:0]                    write_data_i,
    output logic                                init_busy_o,
    output logic                                ready_o,
    output logic                                mem_we_o,
    output logic [lanes(width, byte_width)-1:0] mem_be_o,
    output logic [depth_bits-1:0]               mem_addr_o,
    output logic [width-1:0]                    mem_data_o
);
    init_state_e           state_q, state_d;
    logic [depth_bits-1:0] init_addr_q, init_addr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (clear_on_reset != 0) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_READY;
            end
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // INIT owns the write port outright; external writes are simply dropped.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_busy_o = 1'b0;
        ready_o     = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = write_address_i;
        mem_data_o  = write_data_i;
        unique case (state_q)
            ST_INIT: begin
                init_busy_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = '1;
                mem_addr_o  = init_addr_q;
                mem_data_o  = '0;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ready_o  = 1'b1;
                mem_we_o = write_en_i;
                mem_be_o = write_byte_en_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_ram_sdp.sv
// Simple dual-port RAM: byte-lane write port, registered read port with
// 1- or 2-cycle latency, read_valid strobe and optional post-reset zero clear.
module memory_ram_sdp
    import memory_pkg::*;
#(
    parameter int width          = 32,
    parameter int depth_bits     = 4,
    parameter int byte_width     = 8,
    parameter int read_latency   = 1,
    parameter int write_first    = 0,
    parameter int clear_on_reset = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write_en,
    input  logic [lanes(width, byte_width)-1:0] write_byte_en,
    input  logic [depth_bits-1:0]               write_address,
    input  logic [width-1:0]                    write_data_in,
    input  logic                                read_en,
    input  logic [depth_bits-1:0]               read_address,
    output logic [width-1:0]                    read_data_out,
    output logic                                read_valid,
    output logic                                init_busy
);
    localparam int LANES = lanes(width, byte_width);
    localparam int DEPTH = 2 ** depth_bits;

    if (width % byte_width != 0) begin : g_bad_width
        $error("memory_ram_sdp: width must be a multiple of byte_width");
    end
    if (read_latency != READ_LATENCY_ONE && read_latency != READ_LATENCY_TWO) begin : g_bad_latency
        $error("memory_ram_sdp: read_latency must be 1 or 2");
    end

    logic [width-1:0]      mem_q [DEPTH];
    logic                  ready;
    logic                  mem_we;
    logic [LANES-1:0]      mem_be;
    logic [depth_bits-1:0] mem_addr;
    logic [width-1:0]      mem_data;

    memory_ram_sdp_init #(
        .width          (width),
        .depth_bits     (depth_bits),
        .byte_width     (byte_width),
        .clear_on_reset (clear_on_reset)
    ) u_init (
        .clk             (clk),
        .reset           (reset),
        .write_en_i      (write_en),
        .write_byte_en_i (write_byte_en),
        .write_address_i (write_address),
        .write_data_i    (write_data_in),
        .init_busy_o     (init_busy),
        .ready_o         (ready),
        .mem_we_o        (mem_we),
        .mem_be_o        (mem_be),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_data)
    );

    // The array has no reset so it maps onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][i*byte_width +: byte_width] <= mem_data[i*byte_width +: byte_width];
                end
            end
        end
    end

    logic             read_fire;
    logic [width-1:0] rd1_data_d;
    logic [width-1:0] rd1_data_q;
    logic             rd1_valid_q;

    // Same-address bypass forwards only the enabled lanes of the new word.
    always_comb begin
        read_fire  = ready & read_en;
        rd1_data_d = mem_q[read_address];
        if (write_first != 0 && ready && write_en && write_address == read_address) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_byte_en[i]) begin
                    rd1_data_d[i*byte_width +: byte_width] = write_data_in[i*byte_width +: byte_width];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
        end else begin
            rd1_valid_q <= read_fire;
            if (read_fire) begin
                rd1_data_q <= rd1_data_d;
            end
        end
    end

    if (read_latency == READ_LATENCY_TWO) begin : g_lat2
        logic [width-1:0] rd2_data_q;
        logic             rd2_valid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd2_valid_q <= 1'b0;
                rd2_data_q  <= '0;
            end else begin
                rd2_valid_q <= rd1_valid_q;
                if (rd1_valid_q) begin
                    rd2_data_q <= rd1_data_q;
                end
            end
        end

        assign read_data_out = rd2_data_q;
        assign read_valid    = rd2_valid_q;
    end else begin : g_lat1
        assign read_data_out = rd1_data_q;
        assign read_valid    = rd1_valid_q;
    end

endmodule

// File: tb/tb_memory_ram_sdp.sv
// Bench for memory_ram_sdp: two instances (defaults, and latency 2 / write-first /
// no clear) share stimulus and are checked every cycle against a behavioural model.
module tb_memory_ram_sdp;

    logic        clk = 1'b0;
    logic        rstA = 1'b0;
    logic        rstB = 1'b0;
    logic        writeEn = 1'b0;
    logic [3:0]  writeByteEn = '0;
    logic [3:0]  writeAddress = '0;
    logic [31:0] writeDataIn = '0;
    logic        readEn = 1'b0;
    logic [3:0]  readAddress = '0;
    logic [31:0] readDataA, readDataB;
    logic        readValidA, readValidB;
    logic        initBusyA, initBusyB;

    int nChecks = 0;
    int nFails = 0;

    memory_ram_sdp dutA (
        .clk           (clk),
        .reset         (rstA),
        .write_en      (writeEn),
        .write_byte_en (writeByteEn),
        .write_address (writeAddress),
        .write_data_in (writeDataIn),
        .read_en       (readEn),
        .read_address  (readAddress),
        .read_data_out (readDataA),
        .read_valid    (readValidA),
        .init_busy     (initBusyA)
    );

    memory_ram_sdp #(
        .read_latency   (2),
        .write_first    (1),
        .clear_on_reset (0)
    ) dutB (
        .clk           (clk),
        .reset         (rstB),
        .write_en      (writeEn),
        .write_byte_en (writeByteEn),
        .write_address (writeAddress),
        .write_data_in (writeDataIn),
        .read_en       (readEn),
        .read_address  (readAddress),
        .read_data_out (readDataB),
        .read_valid    (readValidB),
        .init_busy     (initBusyB)
    );

    always #5 clk = ~clk;

    // Behavioural model: per instance a word array with per-lane "known" flags,
    // a clear countdown and the read result visible on the output.
    logic [31:0] memModel   [2][16];
    logic [3:0]  knownModel [2][16];
    int          initRem    [2];
    logic        prevValid  [2];
    logic [31:0] prevData   [2];
    logic [3:0]  prevKnown  [2];
    logic        outValid   [2];
    logic [31:0] outData    [2];
    logic [3:0]  outKnown   [2];
    int          validCount [2];
    logic [31:0] lastData   [2];

    function automatic int latencyOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord, input logic [31:0] newWord,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = newWord[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] laneMask(input logic [3:0] kn);
        return {{8{kn[3]}}, {8{kn[2]}}, {8{kn[1]}}, {8{kn[0]}}};
    endfunction

    task automatic modelReset(input int k);
        initRem[k]   = (k == 0) ? 16 : 0;
        prevValid[k] = 1'b0;
        outValid[k]  = 1'b0;
        outData[k]   = '0;
        outKnown[k]  = 4'hF;
    endtask

    task automatic modelStep(input int k);
        logic        cur;
        logic [31:0] word;
        logic [3:0]  kn;
        cur  = 1'b0;
        word = '0;
        kn   = '0;
        if (initRem[k] > 0) begin
            memModel[k][16 - initRem[k]]   = '0;
            knownModel[k][16 - initRem[k]] = 4'hF;
            initRem[k]--;
        end else begin
            if (readEn) begin
                cur  = 1'b1;
                word = memModel[k][readAddress];
                kn   = knownModel[k][readAddress];
                if (k == 1 && writeEn && writeAddress == readAddress) begin
                    word = mergeLanes(word, writeDataIn, writeByteEn);
                    kn   = kn | writeByteEn;
                end
            end
            if (writeEn) begin
                memModel[k][writeAddress]   = mergeLanes(memModel[k][writeAddress], writeDataIn, writeByteEn);
                knownModel[k][writeAddress] = knownModel[k][writeAddress] | writeByteEn;
            end
        end
        if (latencyOf(k) == 2) begin
            logic        v2;
            logic [31:0] d2;
            logic [3:0]  k2;
            v2 = prevValid[k];
            d2 = prevData[k];
            k2 = prevKnown[k];
            prevValid[k] = cur;
            prevData[k]  = word;
            prevKnown[k] = kn;
            cur  = v2;
            word = d2;
            kn   = k2;
        end
        outValid[k] = cur;
        if (cur) begin
            outData[k]  = word;
            outKnown[k] = kn;
        end
    endtask

    always @(posedge clk or posedge rstA) begin
        if (rstA) modelReset(0);
        else      modelStep(0);
    end

    always @(posedge clk or posedge rstB) begin
        if (rstB) modelReset(1);
        else      modelStep(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareInstance(input int k, input logic v, input logic b, input logic [31:0] d);
        logic [31:0] m;
        checkOutput($sformatf("read_valid[%0d]", k), 32'(v), 32'(outValid[k]));
        checkOutput($sformatf("init_busy[%0d]", k), 32'(b), 32'(initRem[k] > 0));
        m = laneMask(outKnown[k]);
        if (m != '0) checkOutput($sformatf("read_data[%0d]", k), d & m, outData[k] & m);
        if (v) begin
            validCount[k]++;
            lastData[k] = d;
        end
    endtask

    // Every cycle, away from the active edge, both instances against the model.
    always @(negedge clk) begin
        compareInstance(0, readValidA, initBusyA, readDataA);
        compareInstance(1, readValidB, initBusyB, readDataB);
    end

    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [3:0] wa,
                                 input logic [31:0] wd, input logic re, input logic [3:0] ra);
        writeEn      = we;
        writeByteEn  = be;
        writeAddress = wa;
        writeDataIn  = wd;
        readEn       = re;
        readAddress  = ra;
        @(negedge clk);
    endtask

    task automatic opAndCheck(input string name, input logic we, input logic [3:0] be, input logic [3:0] wa,
                              input logic [31:0] wd, input logic [3:0] ra,
                              input logic [31:0] expA, input logic [31:0] expB);
        int cA, cB;
        cA = validCount[0];
        cB = validCount[1];
        applyStimulus(we, be, wa, wd, 1'b1, ra);
        repeat (3) applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        checkOutput({name, "_countA"}, 32'(validCount[0] - cA), 32'd1);
        checkOutput({name, "_countB"}, 32'(validCount[1] - cB), 32'd1);
        checkOutput({name, "_dataA"}, lastData[0], expA);
        checkOutput({name, "_dataB"}, lastData[1], expB);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        logic sawValid;
        for (int k = 0; k < 2; k++) begin
            validCount[k] = 0;
            lastData[k]   = '0;
            for (int a = 0; a < 16; a++) begin
                memModel[k][a]   = '0;
                knownModel[k][a] = 4'h0;
            end
        end
        #1;
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (2) @(negedge clk);
        rstA = 1'b0;
        rstB = 1'b0;

        // Clear sweep with a read held on address 5.
        readEn      = 1'b1;
        readAddress = 4'd5;
        busyCycles  = 0;
        sawValid    = 1'b0;
        for (int c = 0; c < 40 && initBusyA; c++) begin
            busyCycles++;
            if (readValidA) sawValid = 1'b1;
            @(negedge clk);
        end
        checkOutput("init_busy_cycles", 32'(busyCycles), 32'd16);
        checkOutput("valid_during_init", 32'(sawValid), 32'd0);
        checkOutput("valid_first_ready", 32'(readValidA), 32'd0);
        @(negedge clk);
        readEn = 1'b0;
        checkOutput("first_read_valid", 32'(readValidA), 32'd1);
        checkOutput("first_read_data", readDataA, 32'h0);

        for (int a = 0; a < 16; a++) applyStimulus(1'b1, 4'hF, 4'(a), $urandom, 1'b0, 4'h0);

        // Byte-lane merge.
        applyStimulus(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0);
        applyStimulus(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'h0);
        opAndCheck("byte_en", 1'b0, 4'h0, 4'h0, 32'h0, 4'd3, 32'hAA22CC44, 32'hAA22CC44);

        // Same-address read during write: A returns old word, B the new one.
        applyStimulus(1'b1, 4'hF, 4'd7, 32'h12345678, 1'b0, 4'h0);
        opAndCheck("rdw", 1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 4'd7, 32'h12345678, 32'hDEADBEEF);
        opAndCheck("rdw_after", 1'b0, 4'h0, 4'h0, 32'h0, 4'd7, 32'hDEADBEEF, 32'hDEADBEEF);

        // Back-to-back reads through both latencies.
        applyStimulus(1'b1, 4'hF, 4'd0, 32'h10, 1'b0, 4'h0);
        applyStimulus(1'b1, 4'hF, 4'd1, 32'h11, 1'b0, 4'h0);
        applyStimulus(1'b1, 4'hF, 4'd2, 32'h12, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd0);
        checkOutput("burst0_validA", 32'(readValidA), 32'd1);
        checkOutput("burst0_dataA", readDataA, 32'h10);
        checkOutput("burst0_validB", 32'(readValidB), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1);
        checkOutput("burst1_dataA", readDataA, 32'h11);
        checkOutput("burst1_validB", 32'(readValidB), 32'd1);
        checkOutput("burst1_dataB", readDataB, 32'h10);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2);
        checkOutput("burst2_dataA", readDataA, 32'h12);
        checkOutput("burst2_validB", 32'(readValidB), 32'd1);
        checkOutput("burst2_dataB", readDataB, 32'h11);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        checkOutput("burst3_validA", 32'(readValidA), 32'd0);
        checkOutput("burst3_validB", 32'(readValidB), 32'd1);
        checkOutput("burst3_dataB", readDataB, 32'h12);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        checkOutput("burst4_validB", 32'(readValidB), 32'd0);
        checkOutput("burst4_holdB", readDataB, 32'h12);

        // Reset in the middle of a read.
        applyStimulus(1'b1, 4'hF, 4'd9, 32'h55, 1'b0, 4'h0);
        readEn      = 1'b1;
        readAddress = 4'd9;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_validA", 32'(readValidA), 32'd1);
        checkOutput("pre_reset_dataA", readDataA, 32'h55);
        #1;
        rstA = 1'b1;
        rstB = 1'b1;
        #1;
        checkOutput("reset_validA", 32'(readValidA), 32'd0);
        checkOutput("reset_dataA", readDataA, 32'h0);
        checkOutput("reset_validB", 32'(readValidB), 32'd0);
        checkOutput("reset_dataB", readDataB, 32'h0);
        readEn = 1'b0;
        @(negedge clk);
        rstA = 1'b0;
        rstB = 1'b0;

        // Instance without clear keeps its contents and is usable at once.
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd9);
        checkOutput("noclr_busyB", 32'(initBusyB), 32'd0);
        checkOutput("noclr_no_stale_validB", 32'(readValidB), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        checkOutput("noclr_validB", 32'(readValidB), 32'd1);
        checkOutput("noclr_dataB", readDataB, 32'h55);
        for (int c = 0; c < 40 && initBusyA; c++) @(negedge clk);
        checkOutput("reinit_doneA", 32'(initBusyA), 32'd0);
        opAndCheck("cleared9", 1'b0, 4'h0, 4'h0, 32'h0, 4'd9, 32'h0, 32'h55);

        // Random traffic with frequent same-address collisions and one reset.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] wa, ra;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom,
                          1'($urandom_range(0, 1)), ra);
            if (n == 200) begin
                #3;
                rstA = 1'b1;
                rstB = 1'b1;
                @(negedge clk);
                rstA = 1'b0;
                rstB = 1'b0;
            end
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
